// File: rtl/demux_sched_pkg.sv
// Shared sizes and FSM state type for the round-robin demux scheduler.
// Channel count is fixed at eight; select width follows from it.
package demux_sched_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] i);
    return NUM_CH'(1) << i;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping mod 8.
// Optional macro FIXED_PRIO_CH0_EN lets req[0] win regardless of ptr.
module rr_pick8
  import demux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk from the farthest candidate to the nearest so the nearest hit is kept.
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
`ifdef FIXED_PRIO_CH0_EN
    if (req[0]) begin
      found = 1'b1;
      idx   = '0;
    end
`endif
  end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin grant scheduler driving a registered 1-to-8 demux (sel/enable), all outputs registered.
// Optional macro FIXED_PRIO_CH0_EN: channel 0 wins every arbitration and never moves the pointer.
module demux_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  output logic [SEL_W-1:0]  sel,
  output logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic              busy
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t            state, state_n;
  logic [SEL_W-1:0]  ptr, ptr_n;
  logic [7:0]        cnt, cnt_n;
  logic [SEL_W-1:0]  sel_n;
  logic              enable_n;
  logic [NUM_CH-1:0] grant_n;
  logic              busy_n;

  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 3'd7;
      cnt    <= 8'd0;
      sel    <= '0;
      enable <= 1'b0;
      grant  <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      sel    <= sel_n;
      enable <= enable_n;
      grant  <= grant_n;
      busy   <= busy_n;
    end
  end

  // sel doubles as the granted index; it is only rewritten on a new grant.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    cnt_n    = cnt;
    sel_n    = sel;
    enable_n = enable;
    grant_n  = grant;
    busy_n   = busy;
    case (state)
      IDLE, GAP: begin
        if (pick_found) begin
          state_n  = GRANT;
          sel_n    = pick_idx;
          enable_n = 1'b1;
          grant_n  = onehot(pick_idx);
          cnt_n    = 8'd1;
          busy_n   = 1'b1;
        end else begin
          state_n  = IDLE;
          enable_n = 1'b0;
          grant_n  = '0;
          cnt_n    = 8'd0;
          busy_n   = 1'b0;
        end
      end
      GRANT: begin
        if (!req[sel] || cnt == HOLD_LIM) begin
          state_n  = GAP;
          enable_n = 1'b0;
          grant_n  = '0;
          busy_n   = 1'b1;
`ifdef FIXED_PRIO_CH0_EN
          if (sel != '0) ptr_n = sel;
`else
          ptr_n = sel;
`endif
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n  = IDLE;
        enable_n = 1'b0;
        grant_n  = '0;
        busy_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Scoreboard bench for demux_rr_sched: HOLD_MAX=16 instance plus a HOLD_MAX=1 instance.
module tb_demux_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] req1 = 8'h00;
  logic [2:0] sel, sel1;
  logic       en, en1;
  logic [7:0] gr, gr1;
  logic       busy, busy1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic       en;
    logic [2:0] sel;
    logic       busy;
    logic       fast;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  demux_rr_sched #(.HOLD_MAX(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel), .enable(en), .grant(gr), .busy(busy)
  );

  demux_rr_sched #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1),
    .sel(sel1), .enable(en1), .grant(gr1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of req, queue the expected registered outputs, compare after the edge.
  task automatic step(input logic [7:0] r, input logic e_en, input logic [2:0] e_sel,
                      input logic e_busy, input logic fast);
    exp_t e;
    if (fast) req1 = r; else req = r;
    e.en = e_en; e.sel = e_sel; e.busy = e_busy; e.fast = fast;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.fast) begin
      chk("enable_h1", 32'(en1), 32'(e.en));
      chk("sel_h1", 32'(sel1), 32'(e.sel));
      chk("grant_h1", 32'(gr1), e.en ? (32'd1 << e.sel) : 32'd0);
      chk("busy_h1", 32'(busy1), 32'(e.busy));
    end else begin
      chk("enable", 32'(en), 32'(e.en));
      chk("sel", 32'(sel), 32'(e.sel));
      chk("grant", 32'(gr), e.en ? (32'd1 << e.sel) : 32'd0);
      chk("busy", 32'(busy), 32'(e.busy));
    end
  endtask

  task automatic grant_slot(input logic [7:0] r, input logic [2:0] ch, input int len, input logic fast);
    for (int i = 0; i < len; i++) step(r, 1'b1, ch, 1'b1, fast);
  endtask

  task automatic gap(input logic [7:0] r, input logic [2:0] ch, input logic fast);
    step(r, 1'b0, ch, 1'b1, fast);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 8'h00;
    req1 = 8'h00;
    #1;
    chk("rst_enable", 32'(en), 32'd0);
    chk("rst_grant", 32'(gr), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enable_h1", 32'(en1), 32'd0);
    chk("rst_grant_h1", 32'(gr1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] ch;

    // Single channel held: 16-cycle grants separated by one GAP; others cannot preempt.
    do_reset();
    grant_slot(8'h01, 3'd0, 4, 1'b0);
    grant_slot(8'h03, 3'd0, 6, 1'b0);
    grant_slot(8'h01, 3'd0, 6, 1'b0);
    gap(8'h01, 3'd0, 1'b0);
    grant_slot(8'h01, 3'd0, 16, 1'b0);
    gap(8'h01, 3'd0, 1'b0);
    grant_slot(8'h01, 3'd0, 3, 1'b0);
    gap(8'h00, 3'd0, 1'b0);
    step(8'h00, 1'b0, 3'd0, 1'b0, 1'b0);

    // All channels requesting: rotation 0..7,0.
    do_reset();
    for (int k = 0; k < 9; k++) begin
`ifdef FIXED_PRIO_CH0_EN
      ch = 3'd0;
`else
      ch = 3'(k % 8);
`endif
      grant_slot(8'hFF, ch, 16, 1'b0);
      if (k < 8) gap(8'hFF, ch, 1'b0);
    end

    // Early release of channel 2 hands over to channel 5 after one GAP.
    do_reset();
    grant_slot(8'h24, 3'd2, 3, 1'b0);
    gap(8'h20, 3'd2, 1'b0);
    chk("gap_grant2_low", 32'(gr[2]), 32'd0);
    grant_slot(8'h20, 3'd5, 2, 1'b0);

    // Reset mid-grant clears outputs at once; arbitration restarts from ptr=7.
    do_reset();
    grant_slot(8'h40, 3'd6, 4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_enable", 32'(en), 32'd0);
    chk("async_grant", 32'(gr), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_sel", 32'(sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    grant_slot(8'h40, 3'd6, 2, 1'b0);

    // Channels 0 and 7 contending.
    do_reset();
`ifdef FIXED_PRIO_CH0_EN
    for (int k = 0; k < 3; k++) begin
      grant_slot(8'h81, 3'd0, 16, 1'b0);
      gap(8'h81, 3'd0, 1'b0);
    end
`else
    grant_slot(8'h81, 3'd0, 16, 1'b0);
    gap(8'h81, 3'd0, 1'b0);
    grant_slot(8'h81, 3'd7, 16, 1'b0);
    gap(8'h81, 3'd7, 1'b0);
    grant_slot(8'h81, 3'd0, 16, 1'b0);
`endif

    // HOLD_MAX=1: 1, GAP, 3, GAP, 1, ...
    do_reset();
    for (int k = 0; k < 3; k++) begin
      grant_slot(8'h0A, 3'd1, 1, 1'b1);
      gap(8'h0A, 3'd1, 1'b1);
      grant_slot(8'h0A, 3'd3, 1, 1'b1);
      gap(8'h0A, 3'd3, 1'b1);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
